// File: rtl/rom_access_arbiter_pkg.sv
// rom_access_arbiter_pkg: shared defaults, FSM encoding and port index constants
package rom_access_arbiter_pkg;
   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int CNT_WIDTH = 3;
   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/rom_access_arbiter_if.sv
// rom_access_arbiter_if: requester A/B handshakes plus the shared ROM port.
//   slave  = arbiter side (takes requests and ROM data, drives grants, read data, ROM address, busy)
//   master = requester/ROM side
interface rom_access_arbiter_if #(
   parameter int ADDR_WIDTH = rom_access_arbiter_pkg::ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = rom_access_arbiter_pkg::DATA_WIDTH_DEF
);
   logic                  in_req_a;
   logic [ADDR_WIDTH-1:0] in_addr_a;
   logic                  out_gnt_a;
   logic [DATA_WIDTH-1:0] out_rdata_a;
   logic                  out_rvalid_a;
   logic                  in_req_b;
   logic [ADDR_WIDTH-1:0] in_addr_b;
   logic                  out_gnt_b;
   logic [DATA_WIDTH-1:0] out_rdata_b;
   logic                  out_rvalid_b;
   logic [ADDR_WIDTH-1:0] out_rom_addr;
   logic [DATA_WIDTH-1:0] in_rom_data;
   logic                  out_busy;
   modport slave (
      input  in_req_a, in_addr_a, in_req_b, in_addr_b, in_rom_data,
      output out_gnt_a, out_rdata_a, out_rvalid_a, out_gnt_b, out_rdata_b, out_rvalid_b,
             out_rom_addr, out_busy
   );
   modport master (
      output in_req_a, in_addr_a, in_req_b, in_addr_b, in_rom_data,
      input  out_gnt_a, out_rdata_a, out_rvalid_a, out_gnt_b, out_rdata_b, out_rvalid_b,
             out_rom_addr, out_busy
   );
endinterface

// File: rtl/rom_access_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick.
//   req_a_i/req_b_i = requests, last_i = port granted last, win_o = winner index, any_o = any request
module rr_arbiter_2 import rom_access_arbiter_pkg::*; (
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic last_i,
   output logic win_o,
   output logic any_o
);
   assign any_o = req_a_i | req_b_i;
   // on a tie the port not granted last wins
   assign win_o = (req_a_i & req_b_i) ? ~last_i : (req_b_i ? PORT_B : PORT_A);
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one fixed-latency ROM between two requesters.
//   in_clk/in_rst = clock and async active-high reset
//   bus (slave)   = per-port req/addr in, gnt/rdata/rvalid out; out_rom_addr/in_rom_data to the ROM; out_busy
module rom_access_arbiter import rom_access_arbiter_pkg::*; #(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int READ_LATENCY = 1
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   rom_access_arbiter_if.slave  bus
);
   state_t                state_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  last_q, sel_q, win, any_req;
   logic                  gnt_a_q, gnt_b_q, rvalid_a_q, rvalid_b_q;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;

   rr_arbiter_2 u_rr (
      .req_a_i (bus.in_req_a),
      .req_b_i (bus.in_req_b),
      .last_i  (last_q),
      .win_o   (win),
      .any_o   (any_req)
   );

   assign rom_addr_d = (win == PORT_B) ? bus.in_addr_b : bus.in_addr_a;

   // counter runs READ_LATENCY..0 across WAIT; ROM data is captured on the edge leaving count 0
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_q     <= PORT_B;
         sel_q      <= PORT_A;
         rom_addr_q <= '0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         if (state_q == S_IDLE) begin
            if (any_req) begin
               state_q    <= S_WAIT;
               cnt_q      <= CNT_WIDTH'(READ_LATENCY);
               rom_addr_q <= rom_addr_d;
               sel_q      <= win;
               last_q     <= win;
               gnt_a_q    <= (win == PORT_A);
               gnt_b_q    <= (win == PORT_B);
            end
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end else begin
            state_q <= S_IDLE;
            if (sel_q == PORT_A) begin
               rdata_a_q  <= bus.in_rom_data;
               rvalid_a_q <= 1'b1;
            end else begin
               rdata_b_q  <= bus.in_rom_data;
               rvalid_b_q <= 1'b1;
            end
         end
      end
   end

   assign bus.out_gnt_a    = gnt_a_q;
   assign bus.out_gnt_b    = gnt_b_q;
   assign bus.out_rvalid_a = rvalid_a_q;
   assign bus.out_rvalid_b = rvalid_b_q;
   assign bus.out_rdata_a  = rdata_a_q;
   assign bus.out_rdata_b  = rdata_b_q;
   assign bus.out_rom_addr = rom_addr_q;
   assign bus.out_busy     = (state_q == S_WAIT);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: four arbiters (READ_LATENCY 1..4) on shared stimulus, each with its own ROM model
module tb_rom_access_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_a = 1'b0, req_b = 1'b0;
   logic [15:0] addr_a = '0, addr_b = '0;
   logic [4:1] gnt_a, gnt_b, rv_a, rv_b, busy;
   logic [4:1][7:0] rd_a, rd_b;
   logic [4:1][15:0] rom_addr;
   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h4A;
   endfunction

   for (genvar g = 1; g <= 4; g++) begin : gd
      logic [7:0] pipe [0:3];
      rom_access_arbiter_if bus ();
      assign bus.in_req_a    = req_a;
      assign bus.in_addr_a   = addr_a;
      assign bus.in_req_b    = req_b;
      assign bus.in_addr_b   = addr_b;
      assign bus.in_rom_data = pipe[g-1];
      assign gnt_a[g]    = bus.out_gnt_a;
      assign gnt_b[g]    = bus.out_gnt_b;
      assign rv_a[g]     = bus.out_rvalid_a;
      assign rv_b[g]     = bus.out_rvalid_b;
      assign rd_a[g]     = bus.out_rdata_a;
      assign rd_b[g]     = bus.out_rdata_b;
      assign busy[g]     = bus.out_busy;
      assign rom_addr[g] = bus.out_rom_addr;
      rom_access_arbiter #(.READ_LATENCY(g)) dut (
         .in_clk (clk),
         .in_rst (rst),
         .bus    (bus)
      );
      always @(posedge clk) begin
         pipe[0] <= rom_f(bus.out_rom_addr);
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst)
         for (int n = 1; n <= 4; n++)
            chk($sformatf("exclusive L%0d", n), {gnt_a[n] & gnt_b[n], rv_a[n] & rv_b[n]}, 0);

   typedef struct {
      logic rst, ra;
      logic [15:0] aa;
      logic rb;
      logic [15:0] ab;
      logic [1:0] eg, ev;
      logic eb;
      logic [7:0] eda, edb;
      logic [15:0] erom;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic ra, input logic [15:0] aa,
                               input logic rb, input logic [15:0] ab, input logic [1:0] eg,
                               input logic [1:0] ev, input logic eb, input logic [7:0] eda,
                               input logic [7:0] edb, input logic [15:0] erom);
      vec_t v;
      v.rst = r; v.ra = ra; v.aa = aa; v.rb = rb; v.ab = ab;
      v.eg = eg; v.ev = ev; v.eb = eb; v.eda = eda; v.edb = edb; v.erom = erom;
      return v;
   endfunction

   task automatic rst_seq();
      rst = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t tbl[$];
      logic eg, ev, eg2, ev2;
      // fields: rst ra aa rb ab | {gnt_a,gnt_b} {rv_a,rv_b} busy rdata_a rdata_b rom_addr  (L=1 instance)
      tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h00, 8'h00, 16'h0000));
      tbl.push_back(mk(1, 1, 16'h0010, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h00, 8'h00, 16'h0000));
      tbl.push_back(mk(0, 1, 16'h0010, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h00, 8'h00, 16'h0000));
      tbl.push_back(mk(0, 0, 16'h0010, 0, 16'h0000, 2'b10, 2'b00, 1, 8'h00, 8'h00, 16'h0010));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 1, 8'h00, 8'h00, 16'h0010));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b10, 0, 8'h5A, 8'h00, 16'h0010));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h5A, 8'h00, 16'h0010));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h00, 8'h00, 16'h0000));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b00, 2'b00, 0, 8'h00, 8'h00, 16'h0000));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b10, 2'b00, 1, 8'h00, 8'h00, 16'h0001));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b00, 2'b00, 1, 8'h00, 8'h00, 16'h0001));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b00, 2'b10, 0, 8'h4B, 8'h00, 16'h0001));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b01, 2'b00, 1, 8'h4B, 8'h00, 16'h0002));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b00, 2'b00, 1, 8'h4B, 8'h00, 16'h0002));
      tbl.push_back(mk(0, 1, 16'h0001, 1, 16'h0002, 2'b00, 2'b01, 0, 8'h4B, 8'h48, 16'h0002));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 1, 8'h4B, 8'h48, 16'h0001));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 1, 8'h4B, 8'h48, 16'h0001));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b10, 0, 8'h4B, 8'h48, 16'h0001));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h4B, 8'h48, 16'h0001));
      tick();
      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         req_a = tbl[i].ra;
         addr_a = tbl[i].aa;
         req_b = tbl[i].rb;
         addr_b = tbl[i].ab;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             {gnt_a[1], gnt_b[1], rv_a[1], rv_b[1], busy[1], rd_a[1], rd_b[1], rom_addr[1]},
             {tbl[i].eg, tbl[i].ev, tbl[i].eb, tbl[i].eda, tbl[i].edb, tbl[i].erom});
         tick();
      end

      // B holds its request with a fresh address every cycle
      rst_seq();
      for (int c = 0; c < 22; c++) begin
         req_b = 1'b1;
         addr_b = 16'(16'h0100 + c);
         @(negedge clk);
         for (int n = 1; n <= 4; n++) begin
            eg = (c >= 1) && ((c - 1) % (n + 2) == 0);
            ev = (c >= n + 2) && ((c - n - 2) % (n + 2) == 0);
            chk($sformatf("b2b gnt_b L%0d c%0d", n, c), gnt_b[n], eg);
            chk($sformatf("b2b rvalid_b L%0d c%0d", n, c), rv_b[n], ev);
            if (ev) chk($sformatf("b2b rdata_b L%0d c%0d", n, c), rd_b[n], rom_f(16'(16'h0100 + c - n - 2)));
            chk($sformatf("b2b port a quiet L%0d c%0d", n, c), {gnt_a[n], rv_a[n], rd_a[n]}, 0);
         end
         tick();
      end

      // A in flight, B raises its request during WAIT
      rst_seq();
      for (int c = 0; c < 16; c++) begin
         req_a = (c == 0);
         addr_a = 16'h0030;
         req_b = (c >= 2);
         addr_b = 16'h0040;
         @(negedge clk);
         for (int n = 1; n <= 4; n++) begin
            eg2 = (c >= n + 3) && ((c - n - 3) % (n + 2) == 0);
            ev2 = (c >= 2 * n + 4) && ((c - 2 * n - 4) % (n + 2) == 0);
            chk($sformatf("wait gnt L%0d c%0d", n, c), {gnt_a[n], gnt_b[n]}, {c == 1, eg2});
            chk($sformatf("wait rvalid L%0d c%0d", n, c), {rv_a[n], rv_b[n]}, {c == n + 2, ev2});
            if (c == n + 2) chk($sformatf("wait rdata_a L%0d", n), rd_a[n], 8'h7A);
            if (ev2) chk($sformatf("wait rdata_b L%0d c%0d", n, c), rd_b[n], 8'h0A);
         end
         tick();
      end

      // reset asserted while every instance is in WAIT
      rst_seq();
      req_a = 1'b1;
      addr_a = 16'h0050;
      tick();
      req_a = 1'b0;
      @(negedge clk);
      for (int n = 1; n <= 4; n++) chk($sformatf("mid gnt L%0d", n), {gnt_a[n], busy[n]}, 2'b11);
      tick();
      rst = 1'b1;
      #1;
      for (int n = 1; n <= 4; n++)
         chk($sformatf("mid reset outputs L%0d", n),
             {gnt_a[n], gnt_b[n], rv_a[n], rv_b[n], busy[n], rd_a[n], rd_b[n], rom_addr[n]}, 0);
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int n = 1; n <= 4; n++)
            chk($sformatf("aborted quiet L%0d c%0d", n, c), {gnt_a[n], gnt_b[n], rv_a[n], rv_b[n], busy[n]}, 0);
         tick();
      end
      req_a = 1'b1;
      addr_a = 16'h0061;
      req_b = 1'b1;
      addr_b = 16'h0062;
      tick();
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clk);
      for (int n = 1; n <= 4; n++) begin
         chk($sformatf("post-reset tie L%0d", n), {gnt_a[n], gnt_b[n]}, 2'b10);
         chk($sformatf("post-reset addr L%0d", n), rom_addr[n], 16'h0061);
      end
      repeat (8) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
